// File: rtl/digital_gates_pkg.sv
// Shared definitions for the two-input gate evaluator: result-vector bit
// positions and the reference truth table indexed by {A,B}.
package digital_gates_pkg;

    localparam int unsigned RES_W    = 8;

    localparam int unsigned IDX_AND  = 7;
    localparam int unsigned IDX_OR   = 6;
    localparam int unsigned IDX_NOTA = 5;
    localparam int unsigned IDX_NOTB = 4;
    localparam int unsigned IDX_NAND = 3;
    localparam int unsigned IDX_NOR  = 2;
    localparam int unsigned IDX_XOR  = 1;
    localparam int unsigned IDX_XNOR = 0;

    typedef logic [RES_W-1:0] gate_vec_t;

    // Entry order {A,B} = 00, 01, 10, 11; bit order AND..XNOR, MSB first.
    localparam gate_vec_t EXPECTED_TABLE [0:3] = '{
        8'b0011_1101,
        8'b0110_1010,
        8'b0101_1010,
        8'b1100_0001
    };

endpackage : digital_gates_pkg

// File: rtl/digital_gates_gate_eval.sv
// Combinational evaluation of all eight two-input gate functions from the
// captured operands, packed into one result vector.
module gate_eval
    import digital_gates_pkg::*;
(
    input  logic      a_q_i,
    input  logic      b_q_i,
    output gate_vec_t result_o
);

    // Build the result vector bit by bit from the shared index map.
    always_comb begin
        result_o           = '0;
        result_o[IDX_AND]  = a_q_i & b_q_i;
        result_o[IDX_OR]   = a_q_i | b_q_i;
        result_o[IDX_NOTA] = ~a_q_i;
        result_o[IDX_NOTB] = ~b_q_i;
        result_o[IDX_NAND] = ~(a_q_i & b_q_i);
        result_o[IDX_NOR]  = ~(a_q_i | b_q_i);
        result_o[IDX_XOR]  = a_q_i ^ b_q_i;
        result_o[IDX_XNOR] = ~(a_q_i ^ b_q_i);
    end

endmodule : gate_eval

// File: rtl/digital_gates.sv
// Top level: registers the two operands and fans the evaluated gate vector
// out to the eight discrete output pins.
module digital_gates
    import digital_gates_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic and_out,
    output logic or_out,
    output logic not_out_a,
    output logic not_out_b,
    output logic nand_out,
    output logic nor_out,
    output logic xor_out,
    output logic xnor_out
);

    logic      a_d;
    logic      b_d;
    logic      a_q;
    logic      b_q;
    gate_vec_t gates_s;

    assign a_d = a;
    assign b_d = b;

    // Operand capture; reset forces both operands low without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= 1'b0;
            b_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    gate_eval u_gate_eval (
        .a_q_i    (a_q),
        .b_q_i    (b_q),
        .result_o (gates_s)
    );

    assign and_out   = gates_s[IDX_AND];
    assign or_out    = gates_s[IDX_OR];
    assign not_out_a = gates_s[IDX_NOTA];
    assign not_out_b = gates_s[IDX_NOTB];
    assign nand_out  = gates_s[IDX_NAND];
    assign nor_out   = gates_s[IDX_NOR];
    assign xor_out   = gates_s[IDX_XOR];
    assign xnor_out  = gates_s[IDX_XNOR];

endmodule : digital_gates

// File: tb/tb_digital_gates.sv
// Self-checking bench for digital_gates: a count-based behavioural model
// checked every cycle, plus directed vectors with literal expectations.
module tb_digital_gates;
    import digital_gates_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic and_out, or_out, not_out_a, not_out_b;
    logic nand_out, nor_out, xor_out, xnor_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic ma = 1'b0;
    logic mb = 1'b0;

    logic [7:0] dut_vec;
    assign dut_vec = {and_out, or_out, not_out_a, not_out_b,
                      nand_out, nor_out, xor_out, xnor_out};

    digital_gates dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .and_out   (and_out),
        .or_out    (or_out),
        .not_out_a (not_out_a),
        .not_out_b (not_out_b),
        .nand_out  (nand_out),
        .nor_out   (nor_out),
        .xor_out   (xor_out),
        .xnor_out  (xnor_out)
    );

    always #5 clk = ~clk;

    // Gate outputs derived from how many operands are high.
    function automatic logic [7:0] model_vec(input logic x, input logic y);
        int   n;
        logic g_and, g_or, g_xor;
        n     = int'(x) + int'(y);
        g_and = (n == 2);
        g_or  = (n >= 1);
        g_xor = (n == 1);
        return {g_and, g_or, ~x, ~y, ~g_and, ~g_or, g_xor, ~g_xor};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the sampled operands: values at each rising edge, zero in reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= 1'b0;
            mb <= 1'b0;
        end else begin
            ma <= a;
            mb <= b;
        end
    end

    // Per-cycle comparison against the model plus the complement invariants.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle_model", dut_vec, model_vec(ma, mb));
            chk("cycle_invariant",
                {3'b000, nand_out, nor_out, xnor_out, not_out_a, not_out_b},
                {3'b000, ~and_out, ~or_out, ~xor_out, ~ma, ~mb});
        end
    end

    task automatic drive_cycle(input logic na, input logic nb, input bit glitch);
        @(negedge clk);
        #1;
        if (glitch) begin
            a = 1'($urandom_range(1, 0));
            b = 1'($urandom_range(1, 0));
            #1;
            a = ~a;
            #1;
            b = ~b;
            #1;
        end
        a = na;
        b = nb;
    endtask

    initial begin
        logic [7:0] sweep_exp [0:3];
        logic [1:0] ab;
        sweep_exp[0] = 8'b0011_1101;
        sweep_exp[1] = 8'b0110_1010;
        sweep_exp[2] = 8'b0101_1010;
        sweep_exp[3] = 8'b1100_0001;

        // Pin the model and the package table to hand-computed rows.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            chk("model_row", model_vec(ab[1], ab[0]), sweep_exp[i]);
            chk("pkg_table_row", EXPECTED_TABLE[i], sweep_exp[i]);
        end

        // Reset with a=b=1 and no clock edge yet.
        a = 1'b1;
        b = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("reset_immediate", dut_vec, 8'b0011_1101);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", dut_vec, 8'b0011_1101);

        @(negedge clk);
        #1 rst = 1'b0;

        // Exhaustive sweep, one vector per cycle, visible one edge later.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            drive_cycle(ab[1], ab[0], 1'b0);
            @(posedge clk);
            #1;
            chk("sweep", dut_vec, sweep_exp[i]);
        end

        // Latency: a rises mid-cycle with b=1.
        drive_cycle(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("latency_before", dut_vec, 8'b0110_1010);
        #2 a = 1'b1;
        #1;
        chk("latency_no_comb_path", dut_vec, 8'b0110_1010);
        @(posedge clk);
        #1;
        chk("latency_after", dut_vec, 8'b1100_0001);

        // Asynchronous reset pulse between edges with a=b=1 captured.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_mid", dut_vec, 8'b0011_1101);
        #1 rst = 1'b0;
        #1;
        chk("async_reset_released_no_edge", dut_vec, 8'b0011_1101);
        @(posedge clk);
        #1;
        chk("async_reset_restore", dut_vec, 8'b1100_0001);

        // Random operands with glitches between edges.
        for (int i = 0; i < 1000; i++) begin
            drive_cycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_digital_gates
